// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and helpers for the adder array.
//   MODE_PAIR / MODE_ACC : values of the mode input.
//   clog2()              : ceiling log2, used to size result width and beat counter.
package adder_pkg;

  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_lane.sv
// adder_lane: one lane of the array -- adder, running accumulator and result register.
//   clk, reset   : clock, async active-low reset
//   num_1, num_2 : lane operands
//   acc_en       : fold this beat's sum into the accumulator
//   out_ld       : load acc+sum into the result register and clear the accumulator
//   out_num      : registered lane result
module adder_lane #(
  parameter int DATA_WIDTH = 18,
  parameter int OUT_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] num_1,
  input  logic [DATA_WIDTH-1:0] num_2,
  input  logic                  acc_en,
  input  logic                  out_ld,
  output logic [OUT_WIDTH-1:0]  out_num
);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] total;

  assign sum   = OUT_WIDTH'(num_1) + OUT_WIDTH'(num_2);
  // acc is zero whenever a frame is idle, so pairwise results also go
  // through acc+sum without a separate path.
  assign total = acc + sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      out_num <= '0;
    end else if (out_ld) begin
      out_num <= total;
      acc     <= '0;
    end else if (acc_en) begin
      acc     <= total;
    end
  end

endmodule

// File: rtl/adder_array_pipe.sv
// adder_array_pipe: ARRAY_SIZE independent unsigned adder lanes with
// pairwise (one result per beat) or accumulate (one result per ACC_DEPTH
// beats) operation and valid/ready handshakes on both sides.
//   clk, reset          : clock, async active-low reset
//   enable              : input side may accept beats
//   mode                : 0 pairwise, 1 accumulate (latched at frame start)
//   in_valid/in_ready   : input handshake; num_1/num_2 packed lane operands
//   out_valid/out_ready : output handshake; out_num packed lane results
//   out_last            : result closes a frame
module adder_array_pipe
  import adder_pkg::*;
#(
  parameter  int DATA_WIDTH = 18,
  parameter  int ARRAY_SIZE = 2,
  parameter  int ACC_DEPTH  = 4,
  localparam int OUT_WIDTH  = DATA_WIDTH + 1 + clog2(ACC_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] num_1,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] num_2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH*ARRAY_SIZE-1:0]  out_num,
  output logic                             out_last
);

  localparam int CNT_W = clog2(ACC_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_DEPTH - 1);

  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             accept;
  logic             acc_mode;
  logic             close;
  logic             step;

  assign in_ready = enable && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Mode is sampled live only on the first beat of a frame; mid-frame the
  // latched value rules so a toggling mode cannot split a frame.
  assign acc_mode = ((cnt == '0) ? mode : mode_q) == MODE_ACC;
  assign close    = accept && (!acc_mode || cnt == CNT_LAST);
  assign step     = accept && acc_mode && cnt != CNT_LAST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept && cnt == '0) mode_q <= mode;
      if (close)     cnt <= '0;
      else if (step) cnt <= cnt + CNT_W'(1);
      // A closing accept refills the output in the same cycle it drains,
      // so back-to-back results flow without a bubble.
      if (close) begin
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      adder_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .num_1   (num_1[i*DATA_WIDTH +: DATA_WIDTH]),
        .num_2   (num_2[i*DATA_WIDTH +: DATA_WIDTH]),
        .acc_en  (step),
        .out_ld  (close),
        .out_num (out_num[i*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_adder_array_pipe.sv
module tb_adder_array_pipe;

  localparam int DW = 18;
  localparam int AS = 2;
  localparam int AD = 4;
  localparam int OW = 21;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b1;
  logic            mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*AS-1:0] num_1 = '0;
  logic [DW*AS-1:0] num_2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OW*AS-1:0] out_num;
  logic            out_last;

  int total = 0;
  int bad   = 0;

  adder_array_pipe #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ACC_DEPTH(AD)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_1     (num_1),
    .num_2     (num_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one beat offered for one edge; outputs sampled 1ns after that edge
  task automatic beat(input logic m, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                      input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    mode     = m;
    num_1    = {a1, a0};
    num_2    = {b1, b0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [OW-1:0] lane(input int i);
    return out_num[i*OW +: OW];
  endfunction

  initial begin
    // reset
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_num",   out_num, 0);
    check("rst_last",  out_last, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b1;
    tick();

    // pairwise
    beat(0, 3, 5, 18'h3FFFF, 18'h3FFFF);
    check("pair_valid", out_valid, 1);
    check("pair_l0",    lane(0), 8);
    check("pair_l1",    lane(1), 21'h7FFFE);
    check("pair_last",  out_last, 1);
    tick();
    check("pair_drain", out_valid, 0);

    // accumulate
    beat(1, 1, 2, 18'h3FFFF, 18'h3FFFF);
    check("acc_b1", out_valid, 0);
    beat(1, 3, 4, 18'h3FFFF, 18'h3FFFF);
    check("acc_b2", out_valid, 0);
    beat(1, 5, 6, 18'h3FFFF, 18'h3FFFF);
    check("acc_b3", out_valid, 0);
    beat(1, 7, 8, 18'h3FFFF, 18'h3FFFF);
    check("acc_valid", out_valid, 1);
    check("acc_l0",    lane(0), 36);
    check("acc_l1",    lane(1), 21'h1FFFF8);
    check("acc_last",  out_last, 1);
    tick();
    check("acc_drain", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    beat(0, 1, 1, 2, 2);
    check("bp_valid", out_valid, 1);
    num_1 = {18'd0, 18'd10}; num_2 = {18'd0, 18'd10}; mode = 0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", in_ready, 0);
      tick();
      check("bp_hold_l0", lane(0), 2);
      check("bp_hold_l1", lane(1), 4);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    tick();
    check("bp_r1", lane(0), 20);
    check("bp_v1", out_valid, 1);
    num_1 = {18'd0, 18'd20}; num_2 = {18'd0, 18'd20};
    tick();
    check("bp_r2", lane(0), 40);
    check("bp_v2", out_valid, 1);
    num_1 = {18'd0, 18'd30}; num_2 = {18'd0, 18'd30};
    tick();
    check("bp_r3", lane(0), 60);
    check("bp_v3", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drain", out_valid, 0);

    // mode toggled mid-frame is ignored
    beat(1, 1, 2, 0, 1);
    beat(1, 3, 4, 0, 1);
    beat(0, 5, 6, 0, 1);
    check("mt_b3", out_valid, 0);
    beat(0, 7, 8, 0, 1);
    check("mt_valid", out_valid, 1);
    check("mt_l0",    lane(0), 36);
    check("mt_l1",    lane(1), 4);
    tick();

    // reset mid-frame discards partial sum
    beat(1, 100, 100, 100, 100);
    beat(1, 100, 100, 100, 100);
    reset = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_num",   out_num, 0);
    tick();
    reset = 1'b1;
    tick();
    beat(1, 1, 1, 2, 3);
    beat(1, 1, 1, 2, 3);
    beat(1, 1, 1, 2, 3);
    check("mr_b3", out_valid, 0);
    beat(1, 1, 1, 2, 3);
    check("mr_valid2", out_valid, 1);
    check("mr_l0",     lane(0), 8);
    check("mr_l1",     lane(1), 20);
    tick();

    // enable low mid-frame freezes the frame
    beat(1, 1, 1, 1, 1);
    beat(1, 1, 1, 1, 1);
    enable = 1'b0;
    mode = 1; num_1 = {18'd50, 18'd50}; num_2 = {18'd50, 18'd50}; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("en_ready", in_ready, 0);
      tick();
      check("en_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    enable = 1'b1;
    beat(1, 1, 1, 1, 1);
    check("en_b3", out_valid, 0);
    beat(1, 1, 1, 1, 1);
    check("en_valid2", out_valid, 1);
    check("en_l0",     lane(0), 8);
    check("en_l1",     lane(1), 8);
    check("en_last",   out_last, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_array_pipe.md
ADDER_ARRAY_PIPE -- requirements
Module: adder_array_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 18: width of each lane operand.
REQ-002 Parameter ARRAY_SIZE, default 2: number of independent adder lanes, >= 1.
REQ-003 Parameter ACC_DEPTH, default 4: beats per accumulate frame, >= 2.
REQ-004 Derived constant OUT_WIDTH = DATA_WIDTH + 1 + clog2(ACC_DEPTH): per-lane result width, not overridable.
REQ-005 Ports: clk, reset, enable, mode, in_valid, in_ready, num_1, num_2, out_valid, out_ready, out_num, out_last.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  1 = input side may accept beats; 0 = input side stalled.
REQ-009 mode  input  1  0 = pairwise (one result per beat); 1 = accumulate (one result per ACC_DEPTH beats).
REQ-010 in_valid  input  1  beat on num_1/num_2 is valid.
REQ-011 in_ready  output  1  block can accept a beat this cycle.
REQ-012 num_1, num_2  input  DATA_WIDTH*ARRAY_SIZE  unsigned operands; lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-013 out_valid  output  1  out_num/out_last hold a result.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 out_num  output  OUT_WIDTH*ARRAY_SIZE  lane i result at bits [(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH].
REQ-016 out_last  output  1  1 on the result closing a frame; always 1 in pairwise mode.

Function
REQ-017 Input accepted when in_valid && in_ready; in_ready = enable && (!out_valid || out_ready), combinational.
REQ-018 Lane sum = num_1 lane + num_2 lane, zero-extended to OUT_WIDTH; no saturation, no overflow possible by width rule.
REQ-019 Beat counter cnt in 0..ACC_DEPTH-1; cnt==0 is IDLE, cnt!=0 is ACCUM.
REQ-020 Frame mode latched on accept when cnt==0; mode changes while cnt!=0 ignored until frame closes.
REQ-021 Pairwise accept: out_num <= lane sums, out_last <= 1, out_valid <= 1 next cycle (latency 1); cnt stays 0.
REQ-022 Accumulate accept, cnt<ACC_DEPTH-1: acc lane += sum, cnt += 1, output registers untouched.
REQ-023 Accumulate accept, cnt==ACC_DEPTH-1: out_num <= acc + sum, out_last <= 1, out_valid <= 1 next cycle, acc <= 0, cnt <= 0 (wrap).
REQ-024 out_valid && !out_ready: out_num, out_last held stable.
REQ-025 out_valid && out_ready with no new result loaded: out_valid <= 0 next cycle.
REQ-026 Simultaneous consume and result-producing accept: out_valid stays 1, new result replaces old, no bubble.
REQ-027 enable=0: no accept, acc/cnt frozen; output handshake still completes on out_ready.

Reset
REQ-028 reset low asynchronously clears out_valid, out_last, out_num, acc, cnt, latched mode to 0, including mid-frame (partial sum discarded).
REQ-029 After reset release, in_ready = enable; first accept starts a new frame.

Structure
REQ-030 Shared package adder_pkg holds mode constants MODE_PAIR=0, MODE_ACC=1 and the clog2 function used for OUT_WIDTH.
REQ-031 One sub-module adder_lane (one lane: adder + accumulator + output register), instantiated ARRAY_SIZE times via generate; cnt, mode latch and handshake in top level.

Verification (DATA_WIDTH=18, ARRAY_SIZE=2, ACC_DEPTH=4, OUT_WIDTH=21)
REQ-032 Reset: assert reset with enable=1 -> out_valid=0, out_num=0, out_last=0, in_ready=1.
REQ-033 Pairwise: lane0 3+5, lane1 0x3FFFF+0x3FFFF -> next cycle out_valid=1, lane0=8, lane1=0x7FFFE, out_last=1.
REQ-034 Accumulate: lane0 pairs 1+2,3+4,5+6,7+8; lane1 4x(0x3FFFF+0x3FFFF) -> single out_valid one cycle after 4th beat, lane0=36, lane1=0x1FFFF8, out_last=1; none earlier.
REQ-035 Backpressure: result pending, out_ready=0 for 3 cycles -> in_ready=0, out_num stable; then out_ready=1 with in_valid=1 each cycle -> one result per cycle, no gap.
REQ-036 Mid-frame events: toggle mode to 0 after 2 accumulate beats -> frame still closes after 4 beats; reset after 2 beats -> out_valid=0, next frame of 1+1 x4 yields 8.
REQ-037 enable=0 for 2 cycles mid-frame with in_valid=1 -> in_ready=0, cnt unchanged, resumed frame sums correctly.
